// File: rtl/cpu_oci_access_sched.sv
// cpu_oci_access_sched: shares one debug RAM port between CPU accesses and JTAG OCI commands.
// Define OCI_SCHED_STARVE_GUARD_EN to bound how long a pending JTAG command can be starved by the CPU.

module cpu_oci_access_sched #(
   parameter int ADDR_W       = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              jtag_ovr_clr,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       jtag_rdata,
   output logic              jtag_busy,
   output logic              jtag_overrun
);

   typedef enum logic [1:0] {IDLE, JACC, JRD, CACC} state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state;
   state_t            state_next;
   logic              jtag_pend;
   logic              jtag_wr;
   logic [ADDR_W-1:0] jtag_addr;
   logic [31:0]       jtag_wdata;
   logic              strobe_any;
   logic              strobe_accept;
   logic              strobe_drop;
   logic              grant_jtag;
   logic              grant_cpu;
   logic              jtag_done;
   logic              jtag_ok;
   logic              unused_jdo;

   assign unused_jdo    = ^{jdo[37:35], jdo[2:0]};
   assign strobe_any    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign strobe_accept = strobe_any & ~jtag_pend;
   assign strobe_drop   = strobe_any & jtag_pend;
   assign jtag_busy     = jtag_pend;
   assign cpu_rdata     = mem_rdata;

`ifdef OCI_SCHED_STARVE_GUARD_EN
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   logic [STARVE_W-1:0] starve_cnt;

   // JTAG yields to the CPU until the CPU has been served STARVE_LIMIT times in a row
   assign jtag_ok = !cpu_req || (starve_cnt == STARVE_MAX);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (grant_jtag) begin
         starve_cnt <= '0;
      end else if (grant_cpu && jtag_pend && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end
`else
   assign jtag_ok = !cpu_req;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      grant_jtag = 1'b0;
      grant_cpu  = 1'b0;
      jtag_done  = 1'b0;
      case (state)
         IDLE: begin
            if (jtag_pend && jtag_ok) begin
               grant_jtag = 1'b1;
               state_next = JACC;
            end else if (cpu_req) begin
               grant_cpu  = 1'b1;
               state_next = CACC;
            end
         end
         JACC: begin
            if (jtag_wr) begin
               jtag_done  = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = JRD;
            end
         end
         JRD: begin
            jtag_done  = 1'b1;
            state_next = IDLE;
         end
         CACC: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Pending JTAG command: jdo is only valid during the strobe, so write data is captured here
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         jtag_pend    <= 1'b0;
         jtag_wr      <= 1'b0;
         jtag_addr    <= '0;
         jtag_wdata   <= '0;
         jtag_rdata   <= '0;
         jtag_overrun <= 1'b0;
      end else begin
         if (strobe_accept) begin
            jtag_pend  <= 1'b1;
            jtag_wr    <= take_action_ocimem_b & ~take_action_ocimem_a & ~take_no_action_ocimem_a;
            jtag_wdata <= jdo[34:3];
            if (take_action_ocimem_a) begin
               jtag_addr <= jdo[ADDR_W+16:17];
            end
         end else if (jtag_done) begin
            jtag_pend <= 1'b0;
            jtag_addr <= jtag_addr + ADDR_ONE;
         end
         if (state == JRD) begin
            jtag_rdata <= mem_rdata;
         end
         if (strobe_drop) begin
            jtag_overrun <= 1'b1;
         end else if (jtag_ovr_clr) begin
            jtag_overrun <= 1'b0;
         end
      end
   end

   // RAM port is registered so the strobes line up exactly with the JACC/CACC cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         cpu_gnt    <= 1'b0;
         cpu_rvalid <= 1'b0;
      end else begin
         mem_we     <= (grant_jtag & jtag_wr) | (grant_cpu & cpu_we);
         mem_re     <= (grant_jtag & ~jtag_wr) | (grant_cpu & ~cpu_we);
         cpu_gnt    <= grant_cpu;
         cpu_rvalid <= (state == CACC) & mem_re;
         if (grant_jtag) begin
            mem_addr  <= jtag_addr;
            mem_wdata <= jtag_wdata;
         end else if (grant_cpu) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
         end
      end
   end

endmodule

// File: tb/tb_cpu_oci_access_sched.sv
// tb_cpu_oci_access_sched: scoreboard bench for the CPU/JTAG debug RAM scheduler.
// Starvation expectations follow OCI_SCHED_STARVE_GUARD_EN when the bench is built with it.

module tb_cpu_oci_access_sched;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a;
   logic        take_no_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic        jtag_ovr_clr;
   logic        cpu_req;
   logic        cpu_we;
   logic [7:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_gnt;
   logic        cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic [31:0] jtag_rdata;
   logic        jtag_busy;
   logic        jtag_overrun;

   int total = 0;
   int bad   = 0;

   logic [31:0] ram     [0:255];
   logic [31:0] exp_mem [0:255];
   logic [7:0]  exp_addr;
   logic [31:0] jtag_q [$];
   logic [31:0] cpu_q  [$];

   always #5 clk = ~clk;

   cpu_oci_access_sched #(.ADDR_W(8), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset_n(reset_n), .jdo(jdo),
      .take_action_ocimem_a(take_action_ocimem_a),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .take_action_ocimem_b(take_action_ocimem_b),
      .jtag_ovr_clr(jtag_ovr_clr),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata),
      .jtag_rdata(jtag_rdata), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
   );

   // Debug RAM with one cycle read latency
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_strobe(input int kind, input logic [7:0] a, input logic [31:0] d);
      jdo = '0;
      if (kind == 2) jdo[34:3] = d;
      else jdo[24:17] = a;
      take_action_ocimem_a    = (kind == 0);
      take_no_action_ocimem_a = (kind == 1);
      take_action_ocimem_b    = (kind == 2);
   endtask

   task automatic clear_strobes();
      take_action_ocimem_a    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      take_action_ocimem_b    = 1'b0;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
      int n;
      n = 0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      do begin step(); n++; end while (cpu_gnt !== 1'b1 && n < 20);
      total++;
      if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d) begin
         bad++;
         $display("[TB] FAIL cpu_write: gnt=%b we=%b addr=%h data=%h, required gnt=1 we=1 addr=%h data=%h",
                  cpu_gnt, mem_we, mem_addr, mem_wdata, a, d);
      end
      exp_mem[a] = d;
      cpu_req = 1'b0; cpu_we = 1'b0;
      step();
   endtask

   task automatic cpu_read(input logic [7:0] a);
      int n;
      logic [31:0] e;
      n = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      do begin step(); n++; end while (cpu_gnt !== 1'b1 && n < 20);
      cpu_q.push_back(exp_mem[a]);
      cpu_req = 1'b0;
      step();
      e = cpu_q.pop_front();
      total++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== e) begin
         bad++;
         $display("[TB] FAIL cpu_read %h: rvalid=%b rdata=%h, required rvalid=1 rdata=%h", a, cpu_rvalid, cpu_rdata, e);
      end
   endtask

   task automatic jtag_cmd(input int kind, input logic [7:0] a, input logic [31:0] d);
      int n, seen;
      logic exp_we;
      logic [31:0] e;
      drive_strobe(kind, a, d);
      step();
      clear_strobes();
      if (kind == 0) exp_addr = a;
      exp_we = (kind == 2);
      total++;
      if (jtag_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL jtag_accept: busy=%b, required 1", jtag_busy);
      end
      if (exp_we) exp_mem[exp_addr] = d;
      else jtag_q.push_back(exp_mem[exp_addr]);
      n = 0; seen = 0;
      while (jtag_busy === 1'b1 && n < 30) begin
         step(); n++;
         if ((mem_re === 1'b1 || mem_we === 1'b1) && cpu_gnt !== 1'b1) begin
            seen++;
            total++;
            if (mem_addr !== exp_addr || mem_we !== exp_we || mem_re !== !exp_we || (exp_we && mem_wdata !== d)) begin
               bad++;
               $display("[TB] FAIL jtag_access: addr=%h we=%b re=%b wdata=%h, required addr=%h we=%b",
                        mem_addr, mem_we, mem_re, mem_wdata, exp_addr, exp_we);
            end
         end
      end
      total++;
      if (jtag_busy !== 1'b0 || seen != 1) begin
         bad++;
         $display("[TB] FAIL jtag_complete: busy=%b accesses=%0d, required busy=0 accesses=1", jtag_busy, seen);
      end
      if (!exp_we) begin
         e = jtag_q.pop_front();
         total++;
         if (jtag_rdata !== e) begin
            bad++;
            $display("[TB] FAIL jtag_rdata: got %h, required %h", jtag_rdata, e);
         end
      end
      exp_addr = exp_addr + 8'd1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step(); step();
      total++;
      if ({cpu_gnt, cpu_rvalid, mem_we, mem_re, jtag_busy, jtag_overrun} !== 6'b0 ||
          mem_addr !== 8'h00 || mem_wdata !== 32'h0 || jtag_rdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_state: flags=%b addr=%h wdata=%h rdata=%h, required all zero",
                  {cpu_gnt, cpu_rvalid, mem_we, mem_re, jtag_busy, jtag_overrun}, mem_addr, mem_wdata, jtag_rdata);
      end
      reset_n = 1'b1;
      step();
      exp_addr = 8'h00;
   endtask

   task automatic test_cpu_access();
      for (int i = 0; i < 4; i++) cpu_write(8'h30 + 8'(i), $urandom());
      for (int i = 3; i >= 0; i--) cpu_read(8'h30 + 8'(i));
   endtask

   task automatic test_jtag_read();
      logic [31:0] e;
      cpu_write(8'h10, 32'hDEADBEEF);
      cpu_write(8'h11, 32'hA5A50011);
      drive_strobe(0, 8'h10, 32'h0);
      step();
      clear_strobes();
      jtag_q.push_back(exp_mem[8'h10]);
      step();
      total++;
      if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10 || jtag_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL jtag_read_e1: re=%b we=%b addr=%h busy=%b, required re=1 we=0 addr=10 busy=1",
                  mem_re, mem_we, mem_addr, jtag_busy);
      end
      step();
      total++;
      if (mem_re !== 1'b0 || jtag_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL jtag_read_e2: re=%b busy=%b, required re=0 busy=1", mem_re, jtag_busy);
      end
      step();
      e = jtag_q.pop_front();
      total++;
      if (jtag_busy !== 1'b0 || jtag_rdata !== e) begin
         bad++;
         $display("[TB] FAIL jtag_read_e3: busy=%b rdata=%h, required busy=0 rdata=%h", jtag_busy, jtag_rdata, e);
      end
      exp_addr = 8'h11;
      jtag_cmd(1, 8'h00, 32'h0);
   endtask

   task automatic test_jtag_write();
      cpu_write(8'hFE, 32'h0000FEFE);
      cpu_write(8'h00, 32'h5A5A0000);
      jtag_cmd(0, 8'hFE, 32'h0);
      drive_strobe(2, 8'h00, 32'h12345678);
      step();
      clear_strobes();
      exp_mem[8'hFF] = 32'h12345678;
      step();
      total++;
      if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 8'hFF || mem_wdata !== 32'h12345678) begin
         bad++;
         $display("[TB] FAIL jtag_write_e1: we=%b re=%b addr=%h wdata=%h, required we=1 re=0 addr=ff wdata=12345678",
                  mem_we, mem_re, mem_addr, mem_wdata);
      end
      step();
      total++;
      if (jtag_busy !== 1'b0 || mem_we !== 1'b0) begin
         bad++;
         $display("[TB] FAIL jtag_write_e2: busy=%b we=%b, required 0 0", jtag_busy, mem_we);
      end
      exp_addr = 8'h00;
      jtag_cmd(1, 8'h00, 32'h0);
      cpu_read(8'hFF);
   endtask

   task automatic test_back_to_back();
      int n, seen;
      logic [31:0] e;
      drive_strobe(0, 8'h10, 32'h0);
      step();
      jtag_q.push_back(exp_mem[8'h10]);
      drive_strobe(1, 8'h00, 32'h0);
      step();
      clear_strobes();
      total++;
      if (jtag_overrun !== 1'b1) begin
         bad++;
         $display("[TB] FAIL overrun_set: got %b, required 1", jtag_overrun);
      end
      n = 0; seen = 0;
      while (jtag_busy === 1'b1 && n < 20) begin
         step(); n++;
         if (mem_re === 1'b1) seen++;
      end
      e = jtag_q.pop_front();
      total++;
      if (jtag_busy !== 1'b0 || seen != 0 || jtag_rdata !== e) begin
         bad++;
         $display("[TB] FAIL drop_single_read: busy=%b extra=%0d rdata=%h, required busy=0 extra=0 rdata=%h",
                  jtag_busy, seen, jtag_rdata, e);
      end
      drive_strobe(1, 8'h00, 32'h0);
      step();
      jtag_q.push_back(exp_mem[8'h11]);
      total++;
      if (jtag_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL accept_after_done: busy=%b, required 1", jtag_busy);
      end
      jtag_ovr_clr = 1'b1;
      step();
      clear_strobes();
      jtag_ovr_clr = 1'b0;
      total++;
      if (jtag_overrun !== 1'b1) begin
         bad++;
         $display("[TB] FAIL clr_vs_drop: overrun=%b, required 1", jtag_overrun);
      end
      n = 0;
      while (jtag_busy === 1'b1 && n < 20) begin step(); n++; end
      e = jtag_q.pop_front();
      total++;
      if (jtag_busy !== 1'b0 || jtag_rdata !== e) begin
         bad++;
         $display("[TB] FAIL second_read: busy=%b rdata=%h, required busy=0 rdata=%h", jtag_busy, jtag_rdata, e);
      end
      jtag_ovr_clr = 1'b1;
      step();
      jtag_ovr_clr = 1'b0;
      total++;
      if (jtag_overrun !== 1'b0) begin
         bad++;
         $display("[TB] FAIL overrun_clear: got %b, required 0", jtag_overrun);
      end
      exp_addr = 8'h12;
   endtask

   task automatic test_starvation();
      int n, grants, jseen;
      logic [31:0] e;
      cpu_write(8'h20, 32'hC0FFEE20);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
      step();
      drive_strobe(0, 8'h10, 32'h0);
      step();
      clear_strobes();
      jtag_q.push_back(exp_mem[8'h10]);
      n = 0; grants = 0; jseen = 0;
      while (jtag_busy === 1'b1 && n < 16) begin
         step(); n++;
         if (cpu_gnt === 1'b1 && jseen == 0) grants++;
         if (mem_re === 1'b1 && cpu_gnt !== 1'b1) jseen++;
      end
      total++;
`ifdef OCI_SCHED_STARVE_GUARD_EN
      if (grants != 4 || jseen != 1) begin
         bad++;
         $display("[TB] FAIL starve_guard: cpu grants=%0d jtag accesses=%0d, required 4 and 1", grants, jseen);
      end
`else
      if (jseen != 0 || jtag_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL cpu_priority: jtag accesses=%0d busy=%b, required 0 and 1", jseen, jtag_busy);
      end
`endif
      cpu_req = 1'b0;
      n = 0;
      while (jtag_busy === 1'b1 && n < 20) begin step(); n++; end
      e = jtag_q.pop_front();
      total++;
      if (jtag_busy !== 1'b0 || jtag_rdata !== e) begin
         bad++;
         $display("[TB] FAIL starve_read: busy=%b rdata=%h, required busy=0 rdata=%h", jtag_busy, jtag_rdata, e);
      end
      step();
      exp_addr = 8'h11;
   endtask

   task automatic test_reset_in_jrd();
      drive_strobe(0, 8'h10, 32'h0);
      step();
      clear_strobes();
      step();
      drive_strobe(1, 8'h00, 32'h0);
      step();
      clear_strobes();
      reset_n = 1'b0;
      step();
      total++;
      if ({cpu_gnt, cpu_rvalid, mem_we, mem_re, jtag_busy, jtag_overrun} !== 6'b0 ||
          mem_addr !== 8'h00 || mem_wdata !== 32'h0 || jtag_rdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_in_jrd: flags=%b addr=%h wdata=%h rdata=%h, required all zero",
                  {cpu_gnt, cpu_rvalid, mem_we, mem_re, jtag_busy, jtag_overrun}, mem_addr, mem_wdata, jtag_rdata);
      end
      reset_n = 1'b1;
      step();
      exp_addr = 8'h00;
      jtag_cmd(1, 8'h00, 32'h0);
   endtask

   initial begin
      reset_n = 1'b0;
      jdo = '0;
      clear_strobes();
      jtag_ovr_clr = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      exp_addr = 8'h00;
      test_reset();
      test_cpu_access();
      test_jtag_read();
      test_jtag_write();
      test_back_to_back();
      test_starvation();
      test_reset_in_jrd();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_oci_access_sched.md
CPU_OCI_ACCESS_SCHED -- requirements
Module: cpu_oci_access_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, debug RAM word-address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, number of consecutive CPU grants tolerated while a JTAG command waits.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port jdo  in  38  captured JTAG data word, stable while a strobe is high.
REQ-006 SHALL have port take_action_ocimem_a  in  1  one-cycle strobe: load address from jdo[ADDR_W+16:17], then read.
REQ-007 SHALL have port take_no_action_ocimem_a  in  1  one-cycle strobe: read at current address.
REQ-008 SHALL have port take_action_ocimem_b  in  1  one-cycle strobe: write jdo[34:3] at current address.
REQ-009 SHALL have port jtag_ovr_clr  in  1  clears jtag_overrun.
REQ-010 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in 32  CPU access request, held until grant.
REQ-011 SHALL have ports cpu_gnt out 1, cpu_rvalid out 1, cpu_rdata out 32  CPU grant, read-data valid, read data.
REQ-012 SHALL have ports mem_addr out ADDR_W, mem_wdata out 32, mem_we out 1, mem_re out 1, mem_rdata in 32  shared debug RAM port, read latency 1 cycle.
REQ-013 SHALL have ports jtag_rdata out 32, jtag_busy out 1, jtag_overrun out 1  JTAG read result, command in flight, sticky drop flag.

Function
REQ-014 SHALL hold one pending JTAG command (jtag_pend); a strobe accepted at edge E0 sets jtag_pend and jtag_busy after E0.
REQ-015 SHALL accept a strobe only when jtag_busy=0; a strobe while jtag_busy=1 SHALL be dropped and set jtag_overrun.
REQ-016 SHALL use FSM states IDLE, JACC, JRD, CACC; mem_re/mem_we SHALL be high only in JACC or CACC, one cycle each.
REQ-017 In IDLE, SHALL grant JTAG when jtag_pend=1 and (cpu_req=0 or starve_cnt==STARVE_LIMIT); else SHALL grant CPU when cpu_req=1.
REQ-018 JTAG grant at edge E1 SHALL enter JACC with mem_addr=current address; write: mem_we=1, mem_wdata=jdo[34:3]; read: mem_re=1.
REQ-019 JTAG write SHALL return JACC->IDLE at E2, increment address, clear jtag_pend and jtag_busy at E2.
REQ-020 JTAG read SHALL go JACC->JRD at E2, capture mem_rdata into jtag_rdata at E3, increment address, clear jtag_pend and jtag_busy at E3.
REQ-021 Address increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-022 CPU grant SHALL enter CACC for one cycle with cpu_gnt=1 and mem_* driven from cpu_*; CACC->IDLE unconditionally.
REQ-023 cpu_rvalid SHALL pulse the cycle after a CPU read grant, cpu_rdata equal to mem_rdata in that cycle; cpu_rdata SHALL be don't-care otherwise.
REQ-024 starve_cnt SHALL increment on each CPU grant while jtag_pend=1, saturate at STARVE_LIMIT, clear on JTAG grant.
REQ-025 jtag_ovr_clr and a dropped strobe in the same cycle SHALL leave jtag_overrun=1.
REQ-026 A strobe in the cycle jtag_busy is already 0 after completion SHALL be accepted.

Reset
REQ-027 reset_n=0 at a rising edge SHALL force IDLE, jtag_pend=0, jtag_busy=0, jtag_overrun=0, address=0, starve_cnt=0, jtag_rdata=0, cpu_gnt=0, cpu_rvalid=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
REQ-028 Reset during JACC/JRD/CACC SHALL abort the access without completing it; no address increment.

Configuration
REQ-029 With macro OCI_SCHED_STARVE_GUARD_EN defined, REQ-017/REQ-024 SHALL apply as written.
REQ-030 Without OCI_SCHED_STARVE_GUARD_EN, starve_cnt SHALL not exist and CPU SHALL have strict priority over JTAG.

Verification
REQ-031 ocimem_a with addr 0x10, RAM[0x10]=0xDEADBEEF, cpu_req=0 -> mem_re at E1, jtag_rdata=0xDEADBEEF after E3, address=0x11.
REQ-032 ocimem_b data 0x12345678 at address 0xFF -> mem_we=1, mem_addr=0xFF at E1; address=0x00 after E2.
REQ-033 cpu_req held high continuously, JTAG read pending, guard on -> exactly 4 CPU grants, then JTAG grant; guard off -> JTAG waits until cpu_req=0.
REQ-034 Second strobe one cycle after first -> dropped, jtag_overrun=1; jtag_ovr_clr pulse -> jtag_overrun=0.
REQ-035 reset_n=0 while in JRD -> all outputs per REQ-027 next cycle, jtag_rdata=0, address=0.
